// File: rtl/htar9_pkg.sv
// Shared encodings for the HTAR9 run-control / branch-resolution stage.
package htar9_pkg;

  localparam int unsigned INSTR_W = 9;
  localparam int unsigned OP_W    = 3;
  localparam int unsigned OFF_W   = 6;

  localparam logic [OP_W-1:0]    OP_BR      = 3'b110;
  localparam logic [OP_W-1:0]    OP_JMP     = 3'b111;
  localparam logic [INSTR_W-1:0] INSTR_HALT = 9'b111_000_000;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE,
    RESTART
  } run_state_t;

endpackage

// File: rtl/branch_ctl.sv
// Run sequencer and zero-latency branch decode feeding the program counter.
module branch_ctl
  import htar9_pkg::*;
#(
  parameter int unsigned MAX_CYCLES = 4096,
  parameter int unsigned CNT_W      = 16
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               start,
  input  logic [INSTR_W-1:0] instr,
  input  logic               flag_we,
  input  logic               flag_in,
  output logic               abs_jump,
  output logic               rel_jump,
  output logic [OFF_W-1:0]   branch_offset,
  output logic               pc_reset,
  output logic               init,
  output logic               done,
  output logic               timeout,
  output logic [CNT_W-1:0]   cycle_count
);

  run_state_t       state;
  run_state_t       state_nxt;
  logic             flag;
  logic             flag_nxt;
  logic             timeout_nxt;
  logic [CNT_W-1:0] cnt_nxt;
  logic [OP_W-1:0]  op;
  logic             is_br;
  logic             is_jmp;
  logic             is_halt;
  logic             wd_hit;
  logic             cnt_sat;

  assign op      = instr[INSTR_W-1 -: OP_W];
  assign is_br   = (op == OP_BR);
  assign is_jmp  = (op == OP_JMP);
  assign is_halt = (instr == INSTR_HALT);
  assign wd_hit  = (cycle_count == CNT_W'(MAX_CYCLES - 1));
  assign cnt_sat = (cycle_count == {CNT_W{1'b1}});

  // Next state plus PC controls; PC-facing outputs are combinational so jumps reach the PC this cycle.
  always_comb begin
    state_nxt     = state;
    flag_nxt      = flag;
    cnt_nxt       = cycle_count;
    timeout_nxt   = timeout;
    abs_jump      = 1'b0;
    rel_jump      = 1'b0;
    branch_offset = '0;
    pc_reset      = 1'b0;
    init          = 1'b0;
    done          = 1'b0;

    case (state)
      IDLE: begin
        init     = 1'b1;
        pc_reset = 1'b1;
        if (start) begin
          state_nxt   = RUN;
          cnt_nxt     = '0;
          timeout_nxt = 1'b0;
        end
      end
      RUN: begin
        abs_jump = is_jmp & ~is_halt;
        rel_jump = is_br & flag;
        if (is_br || is_jmp) branch_offset = instr[OFF_W-1:0];
        if (flag_we) flag_nxt = flag_in;
        if (!cnt_sat) cnt_nxt = cycle_count + CNT_W'(1);
        // HALT takes priority over the watchdog when both land on the same cycle.
        if (is_halt) begin
          done        = 1'b1;
          state_nxt   = DONE;
          timeout_nxt = 1'b0;
        end else if (wd_hit) begin
          done        = 1'b1;
          state_nxt   = DONE;
          timeout_nxt = 1'b1;
        end
      end
      DONE: begin
        done = 1'b1;
        if (start) state_nxt = RESTART;
      end
      RESTART: begin
        pc_reset    = 1'b1;
        flag_nxt    = 1'b0;
        cnt_nxt     = '0;
        timeout_nxt = 1'b0;
        state_nxt   = RUN;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      flag        <= 1'b0;
      cycle_count <= '0;
      timeout     <= 1'b0;
    end else begin
      state       <= state_nxt;
      flag        <= flag_nxt;
      cycle_count <= cnt_nxt;
      timeout     <= timeout_nxt;
    end
  end

endmodule

// File: tb/tb_branch_ctl.sv
// Directed bench for branch_ctl: run sequencing, branch decode, watchdog, restart and reset.
module tb_branch_ctl;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic [8:0]  instr;
  logic        flag_we;
  logic        flag_in;
  logic        abs_jump;
  logic        rel_jump;
  logic [5:0]  branch_offset;
  logic        pc_reset;
  logic        init;
  logic        done;
  logic        timeout;
  logic [15:0] cycle_count;

  logic [10:0] ctl;
  logic [10:0] exp;
  int          n_vec = 0;
  int          n_err = 0;

  localparam logic [8:0] I_NOP  = 9'h000;
  localparam logic [8:0] I_HALT = 9'h1C0;
  localparam logic [8:0] I_BRM2 = 9'b110_111110;
  localparam logic [8:0] I_BR3  = 9'b110_000011;
  localparam logic [8:0] I_JMP  = 9'b111_010101;

  branch_ctl #(.MAX_CYCLES(8), .CNT_W(16)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .instr(instr),
    .flag_we(flag_we), .flag_in(flag_in),
    .abs_jump(abs_jump), .rel_jump(rel_jump), .branch_offset(branch_offset),
    .pc_reset(pc_reset), .init(init), .done(done), .timeout(timeout),
    .cycle_count(cycle_count)
  );

  always #5 clk = ~clk;

  // {done, init, pc_reset, abs_jump, rel_jump, branch_offset}
  assign ctl = {done, init, pc_reset, abs_jump, rel_jump, branch_offset};

  task automatic step(input logic st, input logic [8:0] ins, input logic we, input logic fin);
    @(negedge clk);
    start = st; instr = ins; flag_we = we; flag_in = fin;
    #1;
  endtask

  task automatic test_reset;
    @(negedge clk); #1;
    exp = 11'b0_1_1_0_0_000000;
    n_vec++; if (ctl !== exp) begin n_err++; $display("FAIL reset_ctl: got %b want %b", ctl, exp); end
    n_vec++; if (cycle_count !== 16'd0) begin n_err++; $display("FAIL reset_count: got %0d want 0", cycle_count); end
    n_vec++; if (timeout !== 1'b0) begin n_err++; $display("FAIL reset_timeout: got %b want 0", timeout); end
    reset_n = 1'b1;
  endtask

  task automatic test_halt_run;
    step(1'b1, I_NOP, 1'b0, 1'b0);
    exp = 11'b0_1_1_0_0_000000;
    n_vec++; if (ctl !== exp) begin n_err++; $display("FAIL idle_start_ctl: got %b want %b", ctl, exp); end
    for (int k = 0; k < 3; k++) begin
      step(1'b0, I_NOP, 1'b0, 1'b0);
      exp = 11'b0_0_0_0_0_000000;
      n_vec++; if (ctl !== exp) begin n_err++; $display("FAIL run_nop_ctl[%0d]: got %b want %b", k, ctl, exp); end
      n_vec++; if (cycle_count !== 16'(k)) begin n_err++; $display("FAIL run_nop_count[%0d]: got %0d want %0d", k, cycle_count, k); end
    end
    step(1'b0, I_HALT, 1'b0, 1'b0);
    exp = 11'b1_0_0_0_0_000000;
    n_vec++; if (ctl !== exp) begin n_err++; $display("FAIL halt_ctl: got %b want %b", ctl, exp); end
    step(1'b0, I_NOP, 1'b0, 1'b0);
    exp = 11'b1_0_0_0_0_000000;
    n_vec++; if (ctl !== exp) begin n_err++; $display("FAIL done_ctl: got %b want %b", ctl, exp); end
    n_vec++; if (cycle_count !== 16'd4) begin n_err++; $display("FAIL done_count: got %0d want 4", cycle_count); end
    n_vec++; if (timeout !== 1'b0) begin n_err++; $display("FAIL done_timeout: got %b want 0", timeout); end
  endtask

  // From DONE: start -> RESTART -> RUN; first RUN cycle issues BR +3 which must not be taken.
  task automatic test_restart;
    step(1'b1, I_NOP, 1'b0, 1'b0);
    exp = 11'b1_0_0_0_0_000000;
    n_vec++; if (ctl !== exp) begin n_err++; $display("FAIL restart_pre_ctl: got %b want %b", ctl, exp); end
    step(1'b0, I_NOP, 1'b0, 1'b0);
    exp = 11'b0_0_1_0_0_000000;
    n_vec++; if (ctl !== exp) begin n_err++; $display("FAIL restart_ctl: got %b want %b", ctl, exp); end
    step(1'b0, I_BR3, 1'b0, 1'b0);
    exp = 11'b0_0_0_0_0_000011;
    n_vec++; if (ctl !== exp) begin n_err++; $display("FAIL restart_run_ctl: got %b want %b", ctl, exp); end
    n_vec++; if (cycle_count !== 16'd0) begin n_err++; $display("FAIL restart_count: got %0d want 0", cycle_count); end
    n_vec++; if (timeout !== 1'b0) begin n_err++; $display("FAIL restart_timeout: got %b want 0", timeout); end
  endtask

  task automatic test_branch;
    step(1'b0, I_BRM2, 1'b1, 1'b1);
    exp = 11'b0_0_0_0_0_111110;
    n_vec++; if (ctl !== exp) begin n_err++; $display("FAIL br_flag0_ctl: got %b want %b", ctl, exp); end
    step(1'b0, I_BRM2, 1'b0, 1'b0);
    exp = 11'b0_0_0_0_1_111110;
    n_vec++; if (ctl !== exp) begin n_err++; $display("FAIL br_taken_ctl: got %b want %b", ctl, exp); end
    n_vec++; if (cycle_count !== 16'd2) begin n_err++; $display("FAIL br_count: got %0d want 2", cycle_count); end
    step(1'b0, I_JMP, 1'b0, 1'b0);
    exp = 11'b0_0_0_1_0_010101;
    n_vec++; if (ctl !== exp) begin n_err++; $display("FAIL jmp_ctl: got %b want %b", ctl, exp); end
    step(1'b0, I_NOP, 1'b1, 1'b0);
    exp = 11'b0_0_0_0_0_000000;
    n_vec++; if (ctl !== exp) begin n_err++; $display("FAIL nop_ctl: got %b want %b", ctl, exp); end
    step(1'b0, I_BRM2, 1'b1, 1'b1);
    exp = 11'b0_0_0_0_0_111110;
    n_vec++; if (ctl !== exp) begin n_err++; $display("FAIL br_no_bypass_ctl: got %b want %b", ctl, exp); end
    step(1'b0, I_BRM2, 1'b0, 1'b0);
    exp = 11'b0_0_0_0_1_111110;
    n_vec++; if (ctl !== exp) begin n_err++; $display("FAIL br_retaken_ctl: got %b want %b", ctl, exp); end
    n_vec++; if (cycle_count !== 16'd6) begin n_err++; $display("FAIL br_count2: got %0d want 6", cycle_count); end
    // HALT lands on the watchdog cycle (count 7 with MAX_CYCLES 8): HALT must win.
    step(1'b0, I_HALT, 1'b0, 1'b0);
    exp = 11'b1_0_0_0_0_000000;
    n_vec++; if (ctl !== exp) begin n_err++; $display("FAIL halt_wd_ctl: got %b want %b", ctl, exp); end
    step(1'b0, I_NOP, 1'b0, 1'b0);
    n_vec++; if (cycle_count !== 16'd8) begin n_err++; $display("FAIL halt_wd_count: got %0d want 8", cycle_count); end
    n_vec++; if (timeout !== 1'b0) begin n_err++; $display("FAIL halt_wd_timeout: got %b want 0", timeout); end
  endtask

  task automatic test_watchdog;
    for (int k = 1; k < 7; k++) begin
      step(k == 3, I_NOP, 1'b0, 1'b0);
      exp = 11'b0_0_0_0_0_000000;
      n_vec++; if (ctl !== exp) begin n_err++; $display("FAIL wd_run_ctl[%0d]: got %b want %b", k, ctl, exp); end
      n_vec++; if (cycle_count !== 16'(k)) begin n_err++; $display("FAIL wd_run_count[%0d]: got %0d want %0d", k, cycle_count, k); end
    end
    step(1'b0, I_NOP, 1'b0, 1'b0);
    exp = 11'b1_0_0_0_0_000000;
    n_vec++; if (ctl !== exp) begin n_err++; $display("FAIL wd_fire_ctl: got %b want %b", ctl, exp); end
    n_vec++; if (timeout !== 1'b0) begin n_err++; $display("FAIL wd_fire_timeout: got %b want 0", timeout); end
    for (int k = 0; k < 2; k++) begin
      step(1'b0, I_NOP, 1'b0, 1'b0);
      exp = 11'b1_0_0_0_0_000000;
      n_vec++; if (ctl !== exp) begin n_err++; $display("FAIL wd_done_ctl[%0d]: got %b want %b", k, ctl, exp); end
      n_vec++; if (cycle_count !== 16'd8) begin n_err++; $display("FAIL wd_done_count[%0d]: got %0d want 8", k, cycle_count); end
      n_vec++; if (timeout !== 1'b1) begin n_err++; $display("FAIL wd_done_timeout[%0d]: got %b want 1", k, timeout); end
    end
  endtask

  task automatic test_reset_mid_run;
    step(1'b0, I_NOP, 1'b0, 1'b0);
    n_vec++; if (cycle_count !== 16'd1) begin n_err++; $display("FAIL mid_pre_count: got %0d want 1", cycle_count); end
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    exp = 11'b0_1_1_0_0_000000;
    n_vec++; if (ctl !== exp) begin n_err++; $display("FAIL mid_reset_ctl: got %b want %b", ctl, exp); end
    n_vec++; if (cycle_count !== 16'd0) begin n_err++; $display("FAIL mid_reset_count: got %0d want 0", cycle_count); end
    step(1'b0, I_NOP, 1'b0, 1'b0);
    reset_n = 1'b1;
    step(1'b0, I_NOP, 1'b1, 1'b1);
    step(1'b1, I_NOP, 1'b0, 1'b0);
    step(1'b0, I_BRM2, 1'b0, 1'b0);
    exp = 11'b0_0_0_0_0_111110;
    n_vec++; if (ctl !== exp) begin n_err++; $display("FAIL idle_flag_ignored_ctl: got %b want %b", ctl, exp); end
    step(1'b0, I_HALT, 1'b0, 1'b0);
    exp = 11'b1_0_0_0_0_000000;
    n_vec++; if (ctl !== exp) begin n_err++; $display("FAIL post_reset_halt_ctl: got %b want %b", ctl, exp); end
    step(1'b0, I_NOP, 1'b0, 1'b0);
    n_vec++; if (cycle_count !== 16'd2) begin n_err++; $display("FAIL post_reset_count: got %0d want 2", cycle_count); end
  endtask

  initial begin
    reset_n = 1'b0;
    start   = 1'b0;
    instr   = I_NOP;
    flag_we = 1'b0;
    flag_in = 1'b0;
    test_reset();
    test_halt_run();
    test_restart();
    test_branch();
    test_restart();
    test_watchdog();
    test_restart();
    test_reset_mid_run();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
